// File: rtl/gpi_debounce_pkg.sv
// -----------------------------------------------------------------------------
// gpi_debounce_pkg
//
// Shared definitions for the general-purpose input conditioning block:
//   - default parameter values for the synchroniser depth and debounce period
//   - the counter width helper used to size each per-bit stability counter
//   - the per-bit action type decoded every cycle by gpi_debounce_bit
// -----------------------------------------------------------------------------
package gpi_debounce_pkg;

  // 50000 cycles is 1 ms at a 50 MHz system clock.
  localparam int unsigned GpiDebounceCyclesDefault = 50000;
  localparam int unsigned GpiSyncStagesDefault     = 2;

  // Width of a counter that must hold values 0..cycles.
  function automatic int unsigned gpi_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

  // What a single bit does on the next clock edge.
  //   GpiActClear  : synchronised input agrees with the output (STABLE)
  //   GpiActCount  : disagreement still being qualified (PENDING)
  //   GpiActCommit : disagreement held long enough, output takes the input
  typedef enum logic [1:0] {
    GpiActClear  = 2'd0,
    GpiActCount  = 2'd1,
    GpiActCommit = 2'd2
  } gpi_act_e;

endpackage : gpi_debounce_pkg

// File: rtl/gpi_debounce_bit.sv
// -----------------------------------------------------------------------------
// gpi_debounce_bit
//
// One input bit of the debouncer: a SyncStages-deep synchroniser, a stability
// counter, the debounced level flop and (optionally) registered edge pulses.
//
// Configuration macro: GPI_DEBOUNCE_EDGE_EN
//   defined   - rise_o / fall_o come from registered pulse flops
//   undefined - rise_o / fall_o are constant 0, no pulse flops exist
//
// Ports:
//   clk_sys_i   in   system clock
//   rst_sys_ni  in   asynchronous active-low reset
//   gpi_i       in   raw pin, asynchronous to clk_sys_i
//   gpi_o       out  debounced, synchronised level
//   rise_o      out  one-cycle pulse when gpi_o goes 0->1
//   fall_o      out  one-cycle pulse when gpi_o goes 1->0
// -----------------------------------------------------------------------------
module gpi_debounce_bit
  import gpi_debounce_pkg::*;
#(
  parameter int unsigned SyncStages     = GpiSyncStagesDefault,   // legal 2..4
  parameter int unsigned DebounceCycles = GpiDebounceCyclesDefault // >= 1
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic gpi_i,
  output logic gpi_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = gpi_cnt_width(DebounceCycles);
  // Terminal count: the commit happens on the edge that would otherwise take
  // the counter to DebounceCycles, so the counter never needs to wrap.
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser: bit 0 is the metastability-catching stage, the MSB is the
  // first stage safe to use as logic.
  // ---------------------------------------------------------------------------
  logic [SyncStages-1:0] sync_d, sync_q;
  logic                  s;

  assign sync_d = {sync_q[SyncStages-2:0], gpi_i};
  assign s      = sync_q[SyncStages-1];

  // ---------------------------------------------------------------------------
  // Stability counter and debounced level
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            level_d, level_q;
  gpi_act_e        act;
  logic            commit;

  // NOTE: every signal written in an always_comb gets a default on entry, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    act     = GpiActClear;
    cnt_d   = '0;
    level_d = level_q;

    if (s != level_q) begin
      act = (cnt_q == CntMax) ? GpiActCommit : GpiActCount;
    end

    unique case (act)
      GpiActClear:  cnt_d = '0;
      GpiActCount:  cnt_d = cnt_q + 1'b1;
      GpiActCommit: begin
        cnt_d   = '0;
        level_d = s;
      end
      default:      cnt_d = '0;
    endcase
  end

  assign commit = (act == GpiActCommit);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others, independent of ordering.
  // NOTE: the synchroniser is reset too (it is a handful of flops, not a
  // memory) so that a stable-high input re-qualifies cleanly after reset.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign gpi_o = level_q;

  // ---------------------------------------------------------------------------
  // Edge pulses: registered on the same edge as the level change, so they are
  // high in exactly the cycle where gpi_o first shows the new value.
  // ---------------------------------------------------------------------------
`ifdef GPI_DEBOUNCE_EDGE_EN
  logic rise_d, rise_q;
  logic fall_d, fall_q;

  always_comb begin
    rise_d = commit &  s;
    fall_d = commit & ~s;
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  // Commit is still decoded for the level path; pulses are simply not built.
  logic unused_commit;
  assign unused_commit = commit;
  assign rise_o        = 1'b0;
  assign fall_o        = 1'b0;
`endif

endmodule : gpi_debounce_bit

// File: rtl/gpi_debounce.sv
// -----------------------------------------------------------------------------
// gpi_debounce
//
// Conditions the Arty A7 push-buttons / slide switches for the general-purpose
// input port of the demo system. Each bit is synchronised into clk_sys_i,
// debounced independently and optionally turned into rise/fall pulses.
//
// Configuration macro: GPI_DEBOUNCE_EDGE_EN
//   defined   - rise_o, fall_o, changed_o report debounced transitions
//   undefined - rise_o, fall_o, changed_o are constant 0; gpi_o unchanged
//
// Parameters:
//   Width          number of independent input bits
//   SyncStages     synchroniser flops per bit, 2..4
//   DebounceCycles consecutive stable cycles before gpi_o follows, >= 1
//
// Ports:
//   clk_sys_i   in   [1]      system clock
//   rst_sys_ni  in   [1]      asynchronous active-low reset
//   gpi_i       in   [Width]  raw board inputs (asynchronous)
//   gpi_o       out  [Width]  debounced, synchronised levels
//   rise_o      out  [Width]  one-cycle pulse per debounced 0->1
//   fall_o      out  [Width]  one-cycle pulse per debounced 1->0
//   changed_o   out  [1]      OR of all rise_o / fall_o bits
// -----------------------------------------------------------------------------
module gpi_debounce
  import gpi_debounce_pkg::*;
#(
  parameter int unsigned Width          = 8,
  parameter int unsigned SyncStages     = GpiSyncStagesDefault,
  parameter int unsigned DebounceCycles = GpiDebounceCyclesDefault
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] gpi_i,
  output logic [Width-1:0] gpi_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             changed_o
);

  for (genvar i = 0; i < Width; i++) begin : g_bit
    gpi_debounce_bit #(
      .SyncStages     (SyncStages),
      .DebounceCycles (DebounceCycles)
    ) u_bit (
      .clk_sys_i  (clk_sys_i),
      .rst_sys_ni (rst_sys_ni),
      .gpi_i      (gpi_i[i]),
      .gpi_o      (gpi_o[i]),
      .rise_o     (rise_o[i]),
      .fall_o     (fall_o[i])
    );
  end

`ifdef GPI_DEBOUNCE_EDGE_EN
  // Purely combinational from the registered pulse flops, hence coincident.
  assign changed_o = (|rise_o) | (|fall_o);
`else
  assign changed_o = 1'b0;
`endif

endmodule : gpi_debounce

// File: tb/tb_gpi_debounce.sv
// -----------------------------------------------------------------------------
// tb_gpi_debounce
//
// Directed bench for gpi_debounce with Width=8, SyncStages=2,
// DebounceCycles=16 (main DUT) plus a DebounceCycles=1 instance sharing the
// same inputs. Pulse expectations follow GPI_DEBOUNCE_EDGE_EN: without it,
// rise_o / fall_o / changed_o are expected to stay 0 throughout.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_gpi_debounce;

  localparam int W   = 8;
  localparam int S   = 2;
  localparam int D   = 16;
  localparam int Lat = S + D - 1; // edges from first sampling edge to update

`ifdef GPI_DEBOUNCE_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] gpi_i;
  logic [W-1:0] gpi_o, rise_o, fall_o;
  logic         changed_o;
  logic [W-1:0] d1_gpi_o, d1_rise_o, d1_fall_o;
  logic         d1_changed_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gpi_debounce #(.Width(W), .SyncStages(S), .DebounceCycles(D)) dut (
    .clk_sys_i  (clk),
    .rst_sys_ni (rst_n),
    .gpi_i      (gpi_i),
    .gpi_o      (gpi_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .changed_o  (changed_o)
  );

  gpi_debounce #(.Width(W), .SyncStages(S), .DebounceCycles(1)) dut1 (
    .clk_sys_i  (clk),
    .rst_sys_ni (rst_n),
    .gpi_i      (gpi_i),
    .gpi_o      (d1_gpi_o),
    .rise_o     (d1_rise_o),
    .fall_o     (d1_fall_o),
    .changed_o  (d1_changed_o)
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pulse(input logic [W-1:0] v);
    return EdgeEn ? v : '0;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int rises;
    int rise_at;
    logic lvl16, lvl17;

    // ---------------- reset with all inputs high ----------------
    rst_n = 1'b0;
    gpi_i = 8'hFF;
    tick(3);
    check("rst_gpi",     gpi_o,     8'h00);
    check("rst_rise",    rise_o,    8'h00);
    check("rst_fall",    fall_o,    8'h00);
    check("rst_changed", changed_o, 1'b0);

    rst_n = 1'b1;
    tick(Lat);
    check("rel_hold",    gpi_o,     8'h00);
    tick(1);
    check("rel_gpi",     gpi_o,     8'hFF);
    check("rel_rise",    rise_o,    pulse(8'hFF));
    check("rel_changed", changed_o, EdgeEn);
    tick(1);
    check("rel_rise_end",    rise_o,    8'h00);
    check("rel_changed_end", changed_o, 1'b0);

    // ---------------- all bits fall ----------------
    gpi_i = 8'h00;
    tick(Lat);
    check("fall_hold", gpi_o,  8'hFF);
    tick(1);
    check("fall_gpi",  gpi_o,  8'h00);
    check("fall_fall", fall_o, pulse(8'hFF));
    check("fall_rise", rise_o, 8'h00);

    // ---------------- clean press on bit 0 ----------------
    gpi_i = 8'h01;
    tick(2);                                  // edge k+1
    check("d1_hold", d1_gpi_o, 8'h00);
    tick(1);                                  // edge k+2
    check("d1_gpi",     d1_gpi_o,     8'h01);
    check("d1_rise",    d1_rise_o,    pulse(8'h01));
    check("d1_fall",    d1_fall_o,    8'h00);
    check("d1_changed", d1_changed_o, EdgeEn);
    tick(14);                                 // edge k+16
    check("press_hold", gpi_o, 8'h00);
    tick(1);                                  // edge k+17
    check("press_gpi",  gpi_o,  8'h01);
    check("press_rise", rise_o, pulse(8'h01));
    check("press_fall", fall_o, 8'h00);
    tick(1);
    check("press_rise_end", rise_o, 8'h00);

    // ---------------- bounce on bit 3 ----------------
    bad   = 0;
    rises = 0;
    for (int seg = 0; seg < 12; seg++) begin
      gpi_i[3] = (seg % 2 == 0);
      repeat (5) begin
        tick(1);
        if (gpi_o[3] !== 1'b0) bad++;
        if (rise_o[3] !== 1'b0) rises++;
      end
    end
    check("bounce_no_change", bad, 0);
    gpi_i[3] = 1'b1;
    rise_at  = -1;
    lvl16    = 1'bx;
    lvl17    = 1'bx;
    for (int e = 0; e < 22; e++) begin
      tick(1);                                // edge k+e
      if (rise_o[3] === 1'b1) begin
        rises++;
        rise_at = e;
      end
      if (e == 16) lvl16 = gpi_o[3];
      if (e == 17) lvl17 = gpi_o[3];
    end
    check("bounce_lvl16",    lvl16,   1'b0);
    check("bounce_lvl17",    lvl17,   1'b1);
    check("bounce_rise_cnt", rises,   EdgeEn ? 1 : 0);
    check("bounce_rise_at",  rise_at, EdgeEn ? 17 : -1);

    // ---------------- boundary on bit 1: 15 cycles, then 16 ----------------
    gpi_i[1] = 1'b1;
    tick(15);
    gpi_i[1] = 1'b0;
    bad = 0;
    repeat (25) begin
      tick(1);
      if (gpi_o[1] !== 1'b0) bad++;
      if (rise_o[1] !== 1'b0) bad++;
    end
    check("bound15_no_change", bad, 0);

    gpi_i[1] = 1'b1;
    tick(16);                                 // edges k..k+15 sample 1
    gpi_i[1] = 1'b0;
    tick(1);                                  // edge k+16
    check("bound16_hold", gpi_o[1], 1'b0);
    tick(1);                                  // edge k+17
    check("bound16_gpi",  gpi_o[1],  1'b1);
    check("bound16_rise", rise_o[1], EdgeEn);
    tick(40);
    check("bound16_settle", gpi_o, 8'h09);

    // ---------------- simultaneous rise and fall ----------------
    gpi_i = 8'h0F;
    tick(20);
    check("simul_pre", gpi_o, 8'h0F);
    gpi_i = 8'hF0;
    tick(Lat);
    check("simul_hold", gpi_o, 8'h0F);
    tick(1);
    check("simul_gpi",     gpi_o,     8'hF0);
    check("simul_rise",    rise_o,    pulse(8'hF0));
    check("simul_fall",    fall_o,    pulse(8'h0F));
    check("simul_changed", changed_o, EdgeEn);
    tick(1);
    check("simul_rise_end",    rise_o,    8'h00);
    check("simul_fall_end",    fall_o,    8'h00);
    check("simul_changed_end", changed_o, 1'b0);

    // ---------------- reset mid-count (bit 0 counter at 8) ----------------
    gpi_i = 8'hF1;
    tick(10);                                 // edge k+9: counter reached 8
    check("mid_pre", gpi_o, 8'hF0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gpi",     gpi_o,     8'h00);
    check("mid_rst_rise",    rise_o,    8'h00);
    check("mid_rst_fall",    fall_o,    8'h00);
    check("mid_rst_changed", changed_o, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(Lat);
    check("mid_hold", gpi_o, 8'h00);
    tick(1);
    check("mid_gpi",     gpi_o,     8'hF1);
    check("mid_rise",    rise_o,    pulse(8'hF1));
    check("mid_changed", changed_o, EdgeEn);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_gpi_debounce

// File: doc/gpi_debounce.md
# gpi_debounce

Input-conditioning stage that sits between the Arty A7 board pins (push-buttons and slide switches) and the general-purpose input port of `ibex_demo_system`. It synchronises each asynchronous pin into the `clk_sys` domain. It debounces each bit with a per-bit stability counter. It optionally produces single-cycle rise and fall pulses for software polling or interrupt logic. It is instantiated in the FPGA top level alongside `clkgen_xil7series` and feeds the demo system directly.

## Interface
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `Width`, default 8: number of independent input bits.
- `SyncStages`, default 2: synchroniser flops per bit; legal range 2..4.
- `DebounceCycles`, default 50000: consecutive stable cycles required before the output follows the input. 50000 cycles is 1 ms at 50 MHz. Must be ≥1.
- `clk_sys_i`  input  1  system clock.
- `rst_sys_ni`  input  1  asynchronous active-low reset.
- `gpi_i`  input  Width  raw board inputs, asynchronous to `clk_sys_i`.
- `gpi_o`  output  Width  debounced, synchronised level.
- `rise_o`  output  Width  one-cycle pulse per bit on a debounced 0→1 transition.
- `fall_o`  output  Width  one-cycle pulse per bit on a debounced 1→0 transition.
- `changed_o`  output  1  OR of all bits of `rise_o` and `fall_o`.

## Operation
- Per bit, data flows from `gpi_i[i]` through a `SyncStages`-deep flop chain to give `s[i]`, then into the debounce counter, then to `gpi_o[i]`.
- The counter width is `$clog2(DebounceCycles+1)`. Counting saturates by construction and never wraps.
- Each clock edge, per bit, one of three things happens:
  - `s[i] == gpi_o[i]`: the counter clears to 0.
  - `s[i] != gpi_o[i]` and counter < `DebounceCycles-1`: the counter increments.
  - `s[i] != gpi_o[i]` and counter == `DebounceCycles-1`: `gpi_o[i]` takes `s[i]` and the counter clears.
- Any glitch on `s[i]` shorter than `DebounceCycles` cycles clears the counter and never reaches `gpi_o`.
- Per-bit state is effectively two states:
  - STABLE: counter = 0.
  - PENDING: counter > 0.
  - PENDING returns to STABLE either on a mismatch ending (no output change) or on the terminal count (output toggles).
- Bits are fully independent. Simultaneous transitions on several bits each produce their own pulses in the same cycle.
- Reset values:
  - all synchroniser flops = 0
  - counters = 0
  - `gpi_o` = 0, `rise_o` = 0, `fall_o` = 0, `changed_o` = 0
- Reset asserted mid-count discards the pending change. After release, a stable-high input re-qualifies and produces a `rise_o` pulse.

## Timing
- Let edge k be the first rising edge of `clk_sys_i` that samples a new, stable value on `gpi_i[i]`.
  - `s[i]` shows the new value after edge k+SyncStages-1.
  - `gpi_o[i]` updates at edge k+SyncStages+DebounceCycles-1.
- `rise_o`/`fall_o` are registered. They are high for exactly the one cycle in which `gpi_o` first shows the new value.
- `changed_o` is combinational from the registered pulse flops and is coincident with them.
- With `DebounceCycles`=1, `gpi_o` follows `s` with one cycle of delay.
- There is no input-to-output combinational path.

## Configuration
- Macro: `GPI_DEBOUNCE_EDGE_EN`.
- Defined: edge-pulse registers and `changed_o` logic are built as described above.
- Undefined:
  - `rise_o`, `fall_o` and `changed_o` are tied to constant 0.
  - No pulse flops are instantiated.
  - `gpi_o` behaviour is unchanged.
- The port list is identical in both cases.

## Structure
- Package `gpi_debounce_pkg` holds:
  - `GpiDebounceCyclesDefault` (50000)
  - `GpiSyncStagesDefault` (2)
  - the function `gpi_cnt_width(cycles)` returning `$clog2(cycles+1)`
- Sub-module `gpi_debounce_bit`: one synchroniser, counter and level flop, plus optional pulse flops. It is instantiated `Width` times in a generate loop.
- The top module only generates the `changed_o` reduction.

## Test plan
- Reset: hold `rst_sys_ni`=0 with `gpi_i`=8'hFF. Require all outputs = 0. After release, `gpi_o` reaches 8'hFF exactly SyncStages+DebounceCycles edges later, with `rise_o`=8'hFF and `changed_o`=1 for one cycle.
- Clean press: with DebounceCycles=16, raise `gpi_i[0]` before edge k. Require `gpi_o[0]`=1 from edge k+17, `rise_o[0]` high for that single cycle, and `fall_o`=0.
- Bounce: with DebounceCycles=16, toggle `gpi_i[3]` every 5 cycles for 60 cycles, then hold 1. Require no `gpi_o[3]` change during the toggling and exactly one `rise_o[3]` pulse, 17 edges after the final stable sample.
- Boundary: with DebounceCycles=16, apply a mismatch of exactly 15 cycles and require no change. Apply exactly 16 cycles and require the change on the 16th counted edge.
- Simultaneous events: `gpi_i` goes from 8'h0F to 8'hF0 in one cycle. Require `rise_o`=8'hF0 and `fall_o`=8'h0F in the same cycle, with `changed_o`=1 for one cycle.
- Mid-count reset, run both with and without `GPI_DEBOUNCE_EDGE_EN`: pulse `rst_sys_ni` low at counter=8. Require outputs = 0 immediately. With the macro undefined, `rise_o`, `fall_o` and `changed_o` remain 0 in all scenarios.
